wb_port_arbiter: RTL and testbench

- Arbitrates the single register-file write port between the in-order pipeline writeback (MEM/WB stage outputs) and a long-latency result unit (multi-cycle mul/div or load refill).
- Performs the MemtoReg select for the pipeline source.
- Buffers long-latency results in a small FIFO and raises a one-cycle pipeline stall when those results are starved.
- Sits between the MEM/WB register and the register file.

---
 rtl/wb_port_arbiter_if.sv | 47 ++++
 rtl/wb_port_arbiter.sv | 138 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter_if
// Description : Bundle of the pipeline WB slot, the long-latency result offer
//               and the register-file write port around wb_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_port_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2
);
    localparam int PEND_W = $clog2(DEPTH) + 1;

    // Pipeline MEM/WB stage
    logic              wb_valid;
    logic              RegWrite_in;
    logic              MemtoReg_in;
    logic [DATA_W-1:0] ReadData_in;
    logic [DATA_W-1:0] ALU_result_in;
    logic [4:0]        rd_in;

    // Long-latency result unit
    logic              lu_valid;
    logic [DATA_W-1:0] lu_data;
    logic [4:0]        lu_rd;
    logic              lu_ready;

    // Register-file write port and pipeline control
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              stall_pipe;
    logic [PEND_W-1:0] pending;

    modport slave (
        input  wb_valid, RegWrite_in, MemtoReg_in, ReadData_in, ALU_result_in, rd_in,
        input  lu_valid, lu_data, lu_rd,
        output lu_ready, rf_we, rf_waddr, rf_wdata, stall_pipe, pending
    );

    modport master (
        output wb_valid, RegWrite_in, MemtoReg_in, ReadData_in, ALU_result_in, rd_in,
        output lu_valid, lu_data, lu_rd,
        input  lu_ready, rf_we, rf_waddr, rf_wdata, stall_pipe, pending
    );
endinterface
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Shares the register-file write port between the in-order
//               pipeline writeback and a FIFO of long-latency results.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
    parameter int DATA_W       = 64,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                reset,
    wb_port_arbiter_if.slave    bus
);
    localparam int c_ptr_w    = $clog2(DEPTH);
    localparam int c_cnt_w    = c_ptr_w + 1;
    localparam int c_starve_w = $clog2(STARVE_LIMIT + 1);

    localparam logic [c_cnt_w-1:0]    c_depth        = c_cnt_w'(DEPTH);
    localparam logic [c_starve_w-1:0] c_starve_limit = c_starve_w'(STARVE_LIMIT);

    // Registered state
    logic                   r_reset_q;
    logic [DATA_W-1:0]      r_fifo_data [DEPTH];
    logic [4:0]             r_fifo_rd   [DEPTH];
    logic [DEPTH-1:0]       r_fifo_vld;
    logic [c_ptr_w-1:0]     r_wptr;
    logic [c_ptr_w-1:0]     r_rptr;
    logic [c_cnt_w-1:0]     r_count;
    logic [c_starve_w-1:0]  r_starve;
    logic                   r_rf_we;
    logic [4:0]             r_rf_waddr;
    logic [DATA_W-1:0]      r_rf_wdata;
    logic                   r_stall;

    // Combinational decode
    logic                   w_full;
    logic                   w_empty;
    logic                   w_lu_ready;
    logic                   w_pipe_req;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_push_kill;
    logic [DATA_W-1:0]      w_pipe_data;
    logic [DEPTH-1:0]       w_kill;
    logic [c_starve_w-1:0]  w_starve_nxt;

    assign w_full      = (r_count == c_depth);
    assign w_empty     = (r_count == '0);
    assign w_lu_ready  = !w_full && !r_reset_q;
    assign w_pipe_req  = bus.wb_valid && bus.RegWrite_in && (bus.rd_in != 5'd0) && !r_stall;
    // x0 results complete the handshake but are never queued
    assign w_push      = bus.lu_valid && w_lu_ready && (bus.lu_rd != 5'd0);
    assign w_pop       = !w_empty && !w_pipe_req;
    assign w_push_kill = w_pipe_req && (bus.lu_rd == bus.rd_in);
    assign w_pipe_data = bus.MemtoReg_in ? bus.ReadData_in : bus.ALU_result_in;

    // A newer pipeline write to the same rd makes queued results stale
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_kill
            assign w_kill[gi] = w_pipe_req && (r_fifo_rd[gi] == bus.rd_in);
        end
    endgenerate

    always_comb begin
        w_starve_nxt = '0;
        if (!w_empty && !w_pop) begin
            w_starve_nxt = (r_starve == c_starve_limit) ? r_starve : r_starve + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_reset_q  <= 1'b1;
            r_fifo_vld <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_starve   <= '0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_stall    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_rd[i]   <= '0;
            end
        end else begin
            r_reset_q  <= 1'b0;
            r_fifo_vld <= r_fifo_vld & ~w_kill;

            if (w_push) begin
                r_fifo_data[r_wptr] <= bus.lu_data;
                r_fifo_rd[r_wptr]   <= bus.lu_rd;
                r_fifo_vld[r_wptr]  <= !w_push_kill;
                r_wptr              <= r_wptr + 1'b1;
            end

            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            // Forced stall lasts one cycle; the guaranteed pop then clears the count
            r_starve <= w_starve_nxt;
            r_stall  <= (w_starve_nxt == c_starve_limit) && !r_stall;

            if (w_pipe_req) begin
                r_rf_we    <= 1'b1;
                r_rf_waddr <= bus.rd_in;
                r_rf_wdata <= w_pipe_data;
            end else if (w_pop) begin
                r_rf_we    <= r_fifo_vld[r_rptr];
                r_rf_waddr <= r_fifo_rd[r_rptr];
                r_rf_wdata <= r_fifo_data[r_rptr];
            end else begin
                r_rf_we    <= 1'b0;
            end
        end
    end

    assign bus.lu_ready   = w_lu_ready;
    assign bus.rf_we      = r_rf_we;
    assign bus.rf_waddr   = r_rf_waddr;
    assign bus.rf_wdata   = r_rf_wdata;
    assign bus.stall_pipe = r_stall;
    assign bus.pending    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Directed self-checking bench for wb_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 2;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [63:0] data;
        logic        stall;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    wb_port_arbiter_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    wb_port_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH), .STARVE_LIMIT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic pipe(input logic v, input logic rw, input logic m2r, input logic [4:0] rd,
                        input logic [63:0] rdata, input logic [63:0] alu);
        bus.wb_valid      = v;
        bus.RegWrite_in   = rw;
        bus.MemtoReg_in   = m2r;
        bus.rd_in         = rd;
        bus.ReadData_in   = rdata;
        bus.ALU_result_in = alu;
    endtask

    task automatic lu(input logic v, input logic [4:0] rd, input logic [63:0] d);
        bus.lu_valid = v;
        bus.lu_rd    = rd;
        bus.lu_data  = d;
    endtask

    // Queue the expected write-port result for the inputs now driven, clock once, compare
    task automatic cyc(input string tag, input logic we, input logic [4:0] a,
                       input logic [63:0] d, input logic st);
        exp_t e;
        e.we = we; e.addr = a; e.data = d; e.stall = st;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, "_rf_we"}, 64'(bus.rf_we), 64'(e.we));
        if (e.we) begin
            chk({tag, "_waddr"}, 64'(bus.rf_waddr), 64'(e.addr));
            chk({tag, "_wdata"}, bus.rf_wdata, e.data);
        end
        chk({tag, "_stall"}, 64'(bus.stall_pipe), 64'(e.stall));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        pipe(0, 0, 0, 0, 0, 0);
        lu(0, 0, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rf_we",    64'(bus.rf_we),      64'd0);
        chk("rst_waddr",    64'(bus.rf_waddr),   64'd0);
        chk("rst_wdata",    bus.rf_wdata,        64'd0);
        chk("rst_stall",    64'(bus.stall_pipe), 64'd0);
        chk("rst_pending",  64'(bus.pending),    64'd0);
        chk("rst_lu_ready", 64'(bus.lu_ready),   64'd0);
        reset = 1'b0;
        cyc("post_rst", 0, 0, 0, 0);
        chk("ready_after_rst", 64'(bus.lu_ready), 64'd1);

        // Pipeline-only beats, both MemtoReg selections
        pipe(1, 1, 0, 5'd5, 64'h0BAD, 64'h1234);
        cyc("pipe_alu", 1, 5'd5, 64'h1234, 0);
        pipe(1, 1, 1, 5'd6, 64'hDEAD, 64'h5555);
        cyc("pipe_mem", 1, 5'd6, 64'hDEAD, 0);

        // x0 suppression on both sources
        pipe(1, 1, 0, 5'd0, 0, 64'h7777);
        cyc("pipe_x0", 0, 0, 0, 0);
        pipe(0, 0, 0, 0, 0, 0);
        lu(1, 5'd0, 64'h5A);
        cyc("lu_x0", 0, 0, 0, 0);
        chk("lu_x0_pending", 64'(bus.pending), 64'd0);

        // Long-latency result with idle pipeline: written two edges after the push
        lu(1, 5'd7, 64'hAA);
        cyc("lu_push", 0, 0, 0, 0);
        chk("lu_push_pending", 64'(bus.pending), 64'd1);
        lu(0, 0, 0);
        cyc("lu_pop", 1, 5'd7, 64'hAA, 0);
        chk("lu_pop_pending", 64'(bus.pending), 64'd0);

        // Pipeline rd=0 lets the FIFO head drain
        lu(1, 5'd3, 64'h33);
        cyc("x0_fill", 0, 0, 0, 0);
        lu(0, 0, 0);
        pipe(1, 1, 0, 5'd0, 0, 64'h9999);
        cyc("x0_drain", 1, 5'd3, 64'h33, 0);

        // Full FIFO under continuous pipeline writes, then forced stall
        pipe(1, 1, 0, 5'd10, 0, 64'h101);
        lu(1, 5'd11, 64'hB1);
        cyc("full_c1", 1, 5'd10, 64'h101, 0);
        pipe(1, 1, 0, 5'd10, 0, 64'h102);
        lu(1, 5'd12, 64'hB2);
        cyc("full_c2", 1, 5'd10, 64'h102, 0);
        chk("full_pending", 64'(bus.pending), 64'd2);
        chk("full_lu_ready", 64'(bus.lu_ready), 64'd0);
        lu(1, 5'd13, 64'hB3);
        for (int i = 3; i <= 9; i++) begin
            pipe(1, 1, 0, 5'd10, 0, 64'h100 + 64'(i));
            cyc("starve", 1, 5'd10, 64'h100 + 64'(i), (i == 9));
        end
        chk("starve_pending", 64'(bus.pending), 64'd2);
        pipe(1, 1, 0, 5'd10, 0, 64'h10A);
        cyc("stall_pop", 1, 5'd11, 64'hB1, 0);
        chk("stall_pop_pending", 64'(bus.pending), 64'd1);
        chk("stall_pop_ready", 64'(bus.lu_ready), 64'd1);
        cyc("refill", 1, 5'd10, 64'h10A, 0);
        chk("refill_pending", 64'(bus.pending), 64'd2);
        lu(0, 0, 0);
        pipe(0, 0, 0, 0, 0, 0);
        cyc("drain_b2", 1, 5'd12, 64'hB2, 0);
        cyc("drain_b3", 1, 5'd13, 64'hB3, 0);
        chk("drain_pending", 64'(bus.pending), 64'd0);
        cyc("drain_idle", 0, 0, 0, 0);

        // Supersede of a queued entry
        lu(1, 5'd9, 64'h11);
        cyc("sup_fill", 0, 0, 0, 0);
        lu(0, 0, 0);
        pipe(1, 1, 0, 5'd9, 0, 64'h22);
        cyc("sup_pipe", 1, 5'd9, 64'h22, 0);
        pipe(0, 0, 0, 0, 0, 0);
        cyc("sup_killed_pop", 0, 0, 0, 0);
        chk("sup_pending", 64'(bus.pending), 64'd0);
        cyc("sup_idle", 0, 0, 0, 0);

        // Same-cycle push and pipeline write to one rd
        pipe(1, 1, 0, 5'd14, 0, 64'h44);
        lu(1, 5'd14, 64'h99);
        cyc("same_rd", 1, 5'd14, 64'h44, 0);
        chk("same_rd_pending", 64'(bus.pending), 64'd1);
        pipe(0, 0, 0, 0, 0, 0);
        lu(0, 0, 0);
        cyc("same_rd_pop", 0, 0, 0, 0);
        chk("same_rd_empty", 64'(bus.pending), 64'd0);

        // Reset with a full FIFO discards its contents
        pipe(1, 1, 0, 5'd10, 0, 64'h300);
        lu(1, 5'd20, 64'hC0);
        cyc("mid_fill1", 1, 5'd10, 64'h300, 0);
        lu(1, 5'd21, 64'hC1);
        cyc("mid_fill2", 1, 5'd10, 64'h300, 0);
        chk("mid_pending", 64'(bus.pending), 64'd2);
        chk("mid_ready", 64'(bus.lu_ready), 64'd0);
        lu(0, 0, 0);
        reset = 1'b1;
        cyc("mid_rst", 0, 0, 0, 0);
        chk("mid_rst_pending", 64'(bus.pending), 64'd0);
        chk("mid_rst_ready", 64'(bus.lu_ready), 64'd0);
        reset = 1'b0;
        pipe(0, 0, 0, 0, 0, 0);
        cyc("mid_after1", 0, 0, 0, 0);
        chk("mid_after_ready", 64'(bus.lu_ready), 64'd1);
        chk("mid_after_pending", 64'(bus.pending), 64'd0);
        cyc("mid_after2", 0, 0, 0, 0);

        // FIFO still functional after reset
        lu(1, 5'd22, 64'hD0);
        cyc("post_push", 0, 0, 0, 0);
        lu(0, 0, 0);
        cyc("post_pop", 1, 5'd22, 64'hD0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
